// File: rtl/mmio_counter_bridge_pkg.sv
// Shared types and constants for the performance-counter MMIO bridge:
// window defaults, bridge FSM states and counter index map.
package mmio_counter_bridge_pkg;

  localparam logic [15:0] MMIO_BASE_DEFAULT    = 16'hFFE0;
  localparam int          NUM_COUNTERS_DEFAULT = 12;

  typedef enum logic [2:0] {
    MMIO_IDLE   = 3'd0,
    MMIO_RD     = 3'd1,
    MMIO_WR     = 3'd2,
    MMIO_RESP   = 3'd3,
    MMIO_BUBBLE = 3'd4
  } mmio_state_t;

  localparam logic [3:0] CNT_ICACHE_MISS  = 4'd0;
  localparam logic [3:0] CNT_ICACHE_HIT   = 4'd1;
  localparam logic [3:0] CNT_DCACHE_MISS  = 4'd2;
  localparam logic [3:0] CNT_DCACHE_HIT   = 4'd3;
  localparam logic [3:0] CNT_L2_MISS      = 4'd4;
  localparam logic [3:0] CNT_L2_HIT       = 4'd5;
  localparam logic [3:0] CNT_STALL_CYCLES = 4'd6;
  localparam logic [3:0] CNT_BRANCH_TOTAL = 4'd7;
  localparam logic [3:0] CNT_BRANCH_TAKEN = 4'd8;
  localparam logic [3:0] CNT_LOAD_COUNT   = 4'd9;
  localparam logic [3:0] CNT_STORE_COUNT  = 4'd10;
  localparam logic [3:0] CNT_MISPREDICT   = 4'd11;

  // True when idx names an implemented counter (limit = counter count).
  function automatic logic idx_in_range(input logic [3:0] idx, input logic [4:0] limit);
    return ({1'b0, idx} < limit);
  endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational window decode: flags accesses that land in the counter
// window and extracts the halfword counter index.
module mmio_addr_decode
  import mmio_counter_bridge_pkg::*;
#(
  parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic [15:1] address,
  input  logic        read,
  input  logic        write,
  output logic        hit,
  output logic [3:0]  index
);

  logic window_match_s;

  assign window_match_s = (address[15:5] == MMIO_BASE[15:5]);
  assign hit            = (read | write) & window_match_s;
  assign index          = address[4:1];

endmodule

// File: rtl/mmio_counter_bridge.sv
// Routes MEM-stage accesses either to the D-cache or, for the counter window,
// into read/clear strobes for the counter block with a registered response.
module mmio_counter_bridge
  import mmio_counter_bridge_pkg::*;
#(
  parameter logic [15:0] MMIO_BASE    = MMIO_BASE_DEFAULT,
  parameter int          NUM_COUNTERS = NUM_COUNTERS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [15:0] cpu_wdata,
  input  logic [1:0]  cpu_wmask,
  output logic [15:0] cpu_rdata,
  output logic        cpu_resp,
  output logic [15:0] dcache_address,
  output logic        dcache_read,
  output logic        dcache_write,
  output logic [15:0] dcache_wdata,
  output logic [1:0]  dcache_wmask,
  input  logic [15:0] dcache_rdata,
  input  logic        dcache_resp,
  output logic [3:0]  counter,
  output logic        MMIO_read,
  output logic        MMIO_write,
  input  logic [15:0] counter_out
);

  localparam logic [4:0] NUM_LIMIT = 5'(NUM_COUNTERS);

  mmio_state_t state_r;
  mmio_state_t next_state_s;
  logic [3:0]  idx_r;
  logic [15:0] rdata_r;
  logic        hit_s;
  logic [3:0]  index_s;
  logic        idx_valid_s;

  mmio_addr_decode #(
    .MMIO_BASE (MMIO_BASE)
  ) u_decode (
    .address (cpu_address[15:1]),
    .read    (cpu_read),
    .write   (cpu_write),
    .hit     (hit_s),
    .index   (index_s)
  );

  assign idx_valid_s = idx_in_range(idx_r, NUM_LIMIT);
  // Driven only from the latched index so the counter block sees a stable select.
  assign counter     = idx_r;

  // State, latched index and captured read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= MMIO_IDLE;
      idx_r   <= 4'd0;
      rdata_r <= 16'h0000;
    end else begin
      state_r <= next_state_s;
      if ((state_r == MMIO_IDLE) && hit_s) begin
        idx_r <= index_s;
      end
      if (state_r == MMIO_RD) begin
        rdata_r <= idx_valid_s ? counter_out : 16'h0000;
      end else if (state_r == MMIO_WR) begin
        rdata_r <= 16'h0000;
      end
    end
  end

  // Next-state selection; a simultaneous read and write takes the write path.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      MMIO_IDLE: begin
        if (hit_s && cpu_write) begin
          next_state_s = MMIO_WR;
        end else if (hit_s) begin
          next_state_s = MMIO_RD;
        end else begin
          next_state_s = MMIO_IDLE;
        end
      end
      MMIO_RD:     next_state_s = MMIO_RESP;
      MMIO_WR:     next_state_s = MMIO_RESP;
      MMIO_RESP:   next_state_s = MMIO_BUBBLE;
      MMIO_BUBBLE: next_state_s = MMIO_IDLE;
      default:     next_state_s = MMIO_IDLE;
    endcase
  end

  // Output muxing: D-cache passthrough only for idle misses, strobes per state.
  always_comb begin
    dcache_address = cpu_address;
    dcache_wdata   = cpu_wdata;
    dcache_wmask   = cpu_wmask;
    dcache_read    = 1'b0;
    dcache_write   = 1'b0;
    cpu_rdata      = 16'h0000;
    cpu_resp       = 1'b0;
    MMIO_read      = 1'b0;
    MMIO_write     = 1'b0;
    case (state_r)
      MMIO_IDLE: begin
        if (!hit_s) begin
          dcache_read  = cpu_read;
          dcache_write = cpu_write;
          cpu_rdata    = dcache_rdata;
          cpu_resp     = dcache_resp;
        end else begin
          cpu_resp = 1'b0;
        end
      end
      MMIO_RD: begin
        MMIO_read = 1'b1;
      end
      MMIO_WR: begin
        // An empty byte mask or an unimplemented index completes without clearing.
        MMIO_write = (cpu_wmask != 2'b00) && idx_valid_s;
      end
      MMIO_RESP: begin
        cpu_resp  = 1'b1;
        cpu_rdata = rdata_r;
      end
      MMIO_BUBBLE: begin
        cpu_resp = 1'b0;
      end
      default: begin
        cpu_resp = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mmio_counter_bridge.sv
// Directed bench for mmio_counter_bridge: passthrough, window reads/writes,
// out-of-range indices, write priority and mid-transaction reset.
module tb_mmio_counter_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [15:0] cpu_wdata;
  logic [1:0]  cpu_wmask;
  logic [15:0] cpu_rdata;
  logic        cpu_resp;
  logic [15:0] dcache_address;
  logic        dcache_read;
  logic        dcache_write;
  logic [15:0] dcache_wdata;
  logic [1:0]  dcache_wmask;
  logic [15:0] dcache_rdata;
  logic        dcache_resp;
  logic [3:0]  counter;
  logic        MMIO_read;
  logic        MMIO_write;
  logic [15:0] counter_out;

  int total = 0;
  int bad   = 0;

  mmio_counter_bridge dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_address    (cpu_address),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_wdata      (cpu_wdata),
    .cpu_wmask      (cpu_wmask),
    .cpu_rdata      (cpu_rdata),
    .cpu_resp       (cpu_resp),
    .dcache_address (dcache_address),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_wdata   (dcache_wdata),
    .dcache_wmask   (dcache_wmask),
    .dcache_rdata   (dcache_rdata),
    .dcache_resp    (dcache_resp),
    .counter        (counter),
    .MMIO_read      (MMIO_read),
    .MMIO_write     (MMIO_write),
    .counter_out    (counter_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds a request for 'hold' cycles, observes 6 cycles, reports what happened.
  task automatic run_txn(input logic [15:0] addr, input logic rd, input logic wr,
                         input logic [1:0] mask, input int hold,
                         output int n_rd, output int n_wr, output int n_resp,
                         output int rd_cyc, output int resp_cyc,
                         output logic [3:0] rd_idx, output logic [3:0] wr_idx,
                         output logic [15:0] resp_data, output logic dc_any);
    n_rd = 0; n_wr = 0; n_resp = 0; rd_cyc = -1; resp_cyc = -1;
    rd_idx = 4'hF; wr_idx = 4'hF; resp_data = 16'hDEAD; dc_any = 1'b0;
    cpu_address = addr; cpu_read = rd; cpu_write = wr; cpu_wmask = mask;
    cpu_wdata = 16'hA5A5; dcache_resp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == hold) begin
        cpu_read = 1'b0; cpu_write = 1'b0;
      end
      @(negedge clk);
      if (MMIO_read) begin
        if (n_rd == 0) begin rd_cyc = i; rd_idx = counter; end
        n_rd++;
      end
      if (MMIO_write) begin wr_idx = counter; n_wr++; end
      if (cpu_resp) begin resp_cyc = i; resp_data = cpu_rdata; n_resp++; end
      if (dcache_read || dcache_write) dc_any = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    @(negedge clk);
    total++;
    if ({MMIO_read, MMIO_write, cpu_resp} !== 3'b000) begin
      bad++; $display("FAIL reset_strobes: got %b want 000", {MMIO_read, MMIO_write, cpu_resp});
    end
    total++;
    if (counter !== 4'd0) begin
      bad++; $display("FAIL reset_counter: got %0d want 0", counter);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_miss();
    cpu_address = 16'h0000; cpu_read = 1'b1; cpu_write = 1'b0;
    dcache_rdata = 16'h1234; dcache_resp = 1'b0;
    @(negedge clk);
    total++;
    if ({dcache_read, dcache_write, cpu_resp, MMIO_read} !== 4'b1000) begin
      bad++; $display("FAIL miss_load_ctrl: got %b want 1000", {dcache_read, dcache_write, cpu_resp, MMIO_read});
    end
    total++;
    if (dcache_address !== 16'h0000) begin
      bad++; $display("FAIL miss_addr: got %h want 0000", dcache_address);
    end
    dcache_resp = 1'b1;
    #1;
    total++;
    if ({cpu_resp, cpu_rdata} !== {1'b1, 16'h1234}) begin
      bad++; $display("FAIL miss_resp: got %b/%h want 1/1234", cpu_resp, cpu_rdata);
    end
    tick();
    cpu_read = 1'b0; cpu_write = 1'b1; cpu_address = 16'h1000;
    cpu_wdata = 16'hABCD; cpu_wmask = 2'b01; dcache_resp = 1'b0;
    @(negedge clk);
    total++;
    if ({dcache_write, dcache_read, dcache_address, dcache_wdata, dcache_wmask} !==
        {1'b1, 1'b0, 16'h1000, 16'hABCD, 2'b01}) begin
      bad++; $display("FAIL miss_store: got w=%b r=%b a=%h d=%h m=%b want 1 0 1000 abcd 01",
                      dcache_write, dcache_read, dcache_address, dcache_wdata, dcache_wmask);
    end
    tick();
    cpu_write = 1'b0;
    tick();
  endtask

  task automatic test_window_read();
    int n_rd, n_wr, n_resp, rd_cyc, resp_cyc;
    logic [3:0] rd_idx, wr_idx;
    logic [15:0] rdat;
    logic dc_any;
    counter_out = 16'h0042;
    run_txn(16'hFFE2, 1'b1, 1'b0, 2'b11, 4, n_rd, n_wr, n_resp, rd_cyc, resp_cyc,
            rd_idx, wr_idx, rdat, dc_any);
    total++;
    if (n_rd !== 1 || rd_cyc !== 1 || rd_idx !== 4'd1) begin
      bad++; $display("FAIL read_strobe: got n=%0d cyc=%0d idx=%0d want 1 1 1", n_rd, rd_cyc, rd_idx);
    end
    total++;
    if (n_resp !== 1 || resp_cyc !== 3 - 1 || rdat !== 16'h0042) begin
      bad++; $display("FAIL read_resp: got n=%0d cyc=%0d data=%h want 1 2 0042", n_resp, resp_cyc, rdat);
    end
    total++;
    if (dc_any !== 1'b0 || n_wr !== 0) begin
      bad++; $display("FAIL read_isolation: got dcache=%b wr=%0d want 0 0", dc_any, n_wr);
    end
    counter_out = 16'h0BAD;
    run_txn(16'hFFF6, 1'b1, 1'b0, 2'b11, 4, n_rd, n_wr, n_resp, rd_cyc, resp_cyc,
            rd_idx, wr_idx, rdat, dc_any);
    total++;
    if (rd_idx !== 4'd11 || rdat !== 16'h0BAD || n_resp !== 1) begin
      bad++; $display("FAIL read_last_idx: got idx=%0d data=%h resp=%0d want 11 0bad 1", rd_idx, rdat, n_resp);
    end
  endtask

  task automatic test_window_write();
    int n_rd, n_wr, n_resp, rd_cyc, resp_cyc;
    logic [3:0] rd_idx, wr_idx;
    logic [15:0] rdat;
    logic dc_any;
    run_txn(16'hFFE6, 1'b0, 1'b1, 2'b11, 4, n_rd, n_wr, n_resp, rd_cyc, resp_cyc,
            rd_idx, wr_idx, rdat, dc_any);
    total++;
    if (n_wr !== 1 || wr_idx !== 4'd3) begin
      bad++; $display("FAIL write_strobe: got n=%0d idx=%0d want 1 3", n_wr, wr_idx);
    end
    total++;
    if (n_resp !== 1 || resp_cyc !== 2 || rdat !== 16'h0000 || n_rd !== 0 || dc_any !== 1'b0) begin
      bad++; $display("FAIL write_resp: got n=%0d cyc=%0d data=%h rd=%0d dc=%b want 1 2 0000 0 0",
                      n_resp, resp_cyc, rdat, n_rd, dc_any);
    end
    run_txn(16'hFFE0, 1'b0, 1'b1, 2'b00, 4, n_rd, n_wr, n_resp, rd_cyc, resp_cyc,
            rd_idx, wr_idx, rdat, dc_any);
    total++;
    if (n_wr !== 0 || n_resp !== 1) begin
      bad++; $display("FAIL write_nomask: got wr=%0d resp=%0d want 0 1", n_wr, n_resp);
    end
  endtask

  task automatic test_out_of_range();
    int n_rd, n_wr, n_resp, rd_cyc, resp_cyc;
    logic [3:0] rd_idx, wr_idx;
    logic [15:0] rdat;
    logic dc_any;
    counter_out = 16'h5555;
    run_txn(16'hFFF8, 1'b1, 1'b0, 2'b11, 4, n_rd, n_wr, n_resp, rd_cyc, resp_cyc,
            rd_idx, wr_idx, rdat, dc_any);
    total++;
    if (n_resp !== 1 || rdat !== 16'h0000 || dc_any !== 1'b0) begin
      bad++; $display("FAIL oor_read: got resp=%0d data=%h dc=%b want 1 0000 0", n_resp, rdat, dc_any);
    end
    run_txn(16'hFFFE, 1'b0, 1'b1, 2'b11, 4, n_rd, n_wr, n_resp, rd_cyc, resp_cyc,
            rd_idx, wr_idx, rdat, dc_any);
    total++;
    if (n_wr !== 0 || n_resp !== 1) begin
      bad++; $display("FAIL oor_write: got wr=%0d resp=%0d want 0 1", n_wr, n_resp);
    end
  endtask

  task automatic test_both_high();
    int n_rd, n_wr, n_resp, rd_cyc, resp_cyc;
    logic [3:0] rd_idx, wr_idx;
    logic [15:0] rdat;
    logic dc_any;
    run_txn(16'hFFE4, 1'b1, 1'b1, 2'b10, 4, n_rd, n_wr, n_resp, rd_cyc, resp_cyc,
            rd_idx, wr_idx, rdat, dc_any);
    total++;
    if (n_wr !== 1 || wr_idx !== 4'd2 || n_rd !== 0 || n_resp !== 1) begin
      bad++; $display("FAIL both_high: got wr=%0d idx=%0d rd=%0d resp=%0d want 1 2 0 1",
                      n_wr, wr_idx, n_rd, n_resp);
    end
  endtask

  task automatic test_reset_mid();
    counter_out = 16'h0077;
    cpu_address = 16'hFFE2; cpu_read = 1'b1; cpu_write = 1'b0; cpu_wmask = 2'b11;
    tick();
    @(negedge clk);
    total++;
    if (MMIO_read !== 1'b1) begin
      bad++; $display("FAIL rst_mid_pre: got MMIO_read=%b want 1", MMIO_read);
    end
    // Reset is applied so that it is sampled at the end of the RD cycle.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({MMIO_read, MMIO_write, cpu_resp, counter} !== {3'b000, 4'd0}) begin
      bad++; $display("FAIL rst_mid_idle: got rd=%b wr=%b resp=%b cnt=%0d want 0 0 0 0",
                      MMIO_read, MMIO_write, cpu_resp, counter);
    end
    tick();
    @(negedge clk);
    total++;
    if (MMIO_read !== 1'b1 || counter !== 4'd1) begin
      bad++; $display("FAIL rst_mid_reaccept: got rd=%b cnt=%0d want 1 1", MMIO_read, counter);
    end
    tick();
    @(negedge clk);
    total++;
    if (cpu_resp !== 1'b1 || cpu_rdata !== 16'h0077) begin
      bad++; $display("FAIL rst_mid_resp: got %b/%h want 1/0077", cpu_resp, cpu_rdata);
    end
    tick();
    cpu_read = 1'b0;
    tick(); tick();
  endtask

  initial begin
    reset = 1'b1; cpu_address = 16'h0000; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_wdata = 16'h0000; cpu_wmask = 2'b00; dcache_rdata = 16'h0000;
    dcache_resp = 1'b0; counter_out = 16'h0000;
    test_reset();
    test_miss();
    test_window_read();
    test_window_write();
    test_out_of_range();
    test_both_high();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
